i2c_target_regfile: RTL

Clock-synchronous I2C responder (target) for the I2C_MASTER initiator. Oversamples SCL/SDA on the system clock, answers a single fixed 7-bit address, and exposes an internal byte register file that the master writes and reads through an auto-incrementing register pointer. Sits on the shared pulled-up SDA/SCL bus alongside I2C_MASTER. A host-side port reads the register file directly and receives a strobe for each byte the master writes.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_line_sync.sv | 43 ++++
 rtl/i2c_target_regfile.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus framing constants.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } i2c_tgt_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // Eight data bits plus the acknowledge slot.
    localparam int         I2C_BITS      = 9;
    localparam logic [3:0] LAST_DATA_BIT = 4'(I2C_BITS - 2);
    localparam logic [3:0] BYTE_DONE     = 4'(I2C_BITS - 1);

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus edge and START/STOP detection on the
// synchronized lines; idle bus level (high) is the reset state.
module i2c_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o
);

    logic [1:0] scl_ff_q, sda_ff_q;
    logic       scl_p_q, sda_p_q;
    logic       scl_s, sda_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_ff_q <= 2'b11;
            sda_ff_q <= 2'b11;
            scl_p_q  <= 1'b1;
            sda_p_q  <= 1'b1;
        end else begin
            scl_ff_q <= {scl_ff_q[0], scl_i};
            sda_ff_q <= {sda_ff_q[0], sda_i};
            scl_p_q  <= scl_ff_q[1];
            sda_p_q  <= sda_ff_q[1];
        end
    end

    assign scl_s = scl_ff_q[1];
    assign sda_s = sda_ff_q[1];

    assign sda_o       = sda_s;
    assign scl_rise_o  = scl_s & ~scl_p_q;
    assign scl_fall_o  = ~scl_s & scl_p_q;
    // SCL must be high on both samples so an SDA move next to an SCL edge is not a condition.
    assign start_det_o = scl_s & scl_p_q & sda_p_q & ~sda_s;
    assign stop_det_o  = scl_s & scl_p_q & ~sda_p_q & sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target at a fixed address exposing NREGS bytes through an auto-incrementing
// pointer; host side gets a combinational read port and a write strobe per data byte.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEVADDR = 7'h0F,
    parameter int         NREGS   = 4,
    localparam int        PTRW    = $clog2(NREGS)
) (
    input  logic            Clk,
    input  logic            RST,
    inout  wire             SDA,
    input  logic            SCL,
    input  logic [PTRW-1:0] HostSel,
    output logic [7:0]      HostData,
    output logic            WrStrobe,
    output logic [PTRW-1:0] WrAddr,
    output logic [7:0]      WrData,
    output logic            Busy
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_sync (
        .clk_i       (Clk),
        .rst_i       (RST),
        .scl_i       (SCL),
        .sda_i       (SDA),
        .sda_o       (sda_s),
        .scl_rise_o  (scl_rise),
        .scl_fall_o  (scl_fall),
        .start_det_o (start_det),
        .stop_det_o  (stop_det)
    );

    i2c_tgt_state_t  state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      sh_q, sh_d;
    logic [PTRW-1:0] ptr_q, ptr_d;
    logic            oe_q, oe_d;
    logic            busy_q, busy_d;
    logic            rw_q, rw_d;
    logic            nack_q, nack_d;
    logic            wstb_q, wstb_d;
    logic [PTRW-1:0] waddr_q, waddr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      regs_q [NREGS];
    logic [7:0]      byte_in;
    logic [7:0]      rd_byte;

    assign byte_in = {sh_q[6:0], sda_s};
    assign rd_byte = regs_q[ptr_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        ptr_d   = ptr_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        rw_d    = rw_q;
        nack_d  = nack_q;
        wstb_d  = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (stop_det) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d = ST_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        sh_d  = byte_in;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == LAST_DATA_BIT) begin
                            if (state_q == ST_ADDR) begin
                                if (byte_in[7:1] == DEVADDR) begin
                                    state_d = ST_ADDR_ACK;
                                    rw_d    = byte_in[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = ST_IGNORE;
                                end
                            end else if (state_q == ST_PTR) begin
                                ptr_d   = byte_in[PTRW-1:0];
                                state_d = ST_PTR_ACK;
                            end else begin
                                wstb_d  = 1'b1;
                                waddr_d = ptr_q;
                                wdata_d = byte_in;
                                ptr_d   = ptr_q + 1'b1;
                                state_d = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                // First fall after the 8th bit drives ACK, the next one ends the slot.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            cnt_d = 4'd0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                sh_d    = rd_byte;
                                oe_d    = (rd_byte[7] == 1'b0);
                                state_d = ST_RDATA;
                            end else begin
                                oe_d    = 1'b0;
                                state_d = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == BYTE_DONE) begin
                            oe_d    = 1'b0;
                            ptr_d   = ptr_q + 1'b1;
                            cnt_d   = 4'd0;
                            state_d = ST_RDATA_ACK;
                        end else begin
                            oe_d = (sh_q[6] == 1'b0);
                            sh_d = {sh_q[6:0], 1'b0};
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        cnt_d  = 4'd1;
                        nack_d = (sda_s == I2C_NACK);
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        cnt_d = 4'd0;
                        if (nack_q) begin
                            state_d = ST_IGNORE;
                        end else begin
                            sh_d    = rd_byte;
                            oe_d    = (rd_byte[7] == 1'b0);
                            state_d = ST_RDATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            sh_q    <= 8'h00;
            ptr_q   <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            rw_q    <= 1'b0;
            nack_q  <= 1'b0;
            wstb_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            ptr_q   <= ptr_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            rw_q    <= rw_d;
            nack_q  <= nack_d;
            wstb_q  <= wstb_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Commit lags the strobe by a cycle so a same-index host read sees the old byte first.
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
        end else if (wstb_q) begin
            regs_q[waddr_q] <= wdata_q;
        end
    end

    assign SDA      = oe_q ? I2C_ACK : 1'bz;
    assign HostData = regs_q[HostSel];
    assign WrStrobe = wstb_q;
    assign WrAddr   = waddr_q;
    assign WrData   = wdata_q;
    assign Busy     = busy_q;

endmodule
